// File: rtl/imem_loader_if.sv
// Signal bundle between the program loader and its environment: the incoming
// byte stream (valid/ready), the IMEM write port, and the loader status lines.
// The master modport is the loader; the slave modport is the byte source / IMEM
// / top-level glue that observes the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 32,
    parameter int ILEN   = 32
);
    logic [7:0]        rx_data_i;
    logic              rx_valid_i;
    logic              rx_ready_o;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_waddr_o;
    logic [ILEN-1:0]   imem_wdata_o;
    logic              cpu_hold_o;
    logic              done_o;
    logic              err_o;
    logic [15:0]       words_o;

    modport master (
        input  rx_data_i,
        input  rx_valid_i,
        output rx_ready_o,
        output imem_we_o,
        output imem_waddr_o,
        output imem_wdata_o,
        output cpu_hold_o,
        output done_o,
        output err_o,
        output words_o
    );

    modport slave (
        output rx_data_i,
        output rx_valid_i,
        input  rx_ready_o,
        input  imem_we_o,
        input  imem_waddr_o,
        input  imem_wdata_o,
        input  cpu_hold_o,
        input  done_o,
        input  err_o,
        input  words_o
    );
endinterface

// File: rtl/imem_loader.sv
// Byte-stream program loader. Parses frames of the form
//   SYNC, LEN_LO, LEN_HI, N x 4 data bytes (little-endian words), CSUM
// and writes the assembled words to IMEM starting at byte address 0, holding
// the cpu in reset while a load is in progress. CSUM is the mod-256 sum of the
// data bytes only. All outputs are registered and cleared by the async reset.
module imem_loader #(
    parameter int         ILEN              = 32,
    parameter int         IMEM_CAPACITY_KiB = 4,
    parameter int         ADDR_W            = 32,
    parameter logic [7:0] SYNC_BYTE         = 8'hA5
) (
    input  logic           clk_i,
    input  logic           rst_i,
    imem_loader_if.master  bus
);
    localparam int          IMEM_WORDS   = IMEM_CAPACITY_KiB * 256;
    localparam logic [16:0] IMEM_WORDS_L = 17'(IMEM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        lane_q, lane_d;
    logic [23:0]       word_q, word_d;     // lanes 0..2; lane 3 arrives with the write
    logic [7:0]        csum_q, csum_d;
    logic [15:0]       words_q, words_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ILEN-1:0]   wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;

    logic              accept;
    logic [15:0]       len_full;
    logic [15:0]       words_inc;

    assign accept    = bus.rx_valid_i && ready_q;
    assign len_full  = {bus.rx_data_i, len_q[7:0]};
    assign words_inc = words_q + 16'd1;

    // Next-state and registered-output computation for every parser state.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        lane_d  = lane_q;
        word_d  = word_q;
        csum_d  = csum_q;
        words_d = words_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        hold_d  = hold_q;
        done_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            // A sync byte restarts a frame whether idle or recovering from an error.
            S_IDLE, S_ERR: begin
                if (accept && bus.rx_data_i == SYNC_BYTE) begin
                    state_d = S_LEN_LO;
                    hold_d  = 1'b1;
                    err_d   = 1'b0;
                    words_d = 16'd0;
                    lane_d  = 2'd0;
                    csum_d  = 8'd0;
                    len_d   = 16'd0;
                    word_d  = 24'd0;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = bus.rx_data_i;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = bus.rx_data_i;
                    if ({1'b0, len_full} > IMEM_WORDS_L) begin
                        state_d = S_ERR;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d = csum_q + bus.rx_data_i;
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: word_d[7:0]   = bus.rx_data_i;
                        2'd1: word_d[15:8]  = bus.rx_data_i;
                        2'd2: word_d[23:16] = bus.rx_data_i;
                        default: begin
                            // Fourth byte: issue the write with the pre-increment address.
                            we_d    = 1'b1;
                            waddr_d = ADDR_W'({words_q, 2'b00});
                            wdata_d = {bus.rx_data_i, word_q};
                            words_d = words_inc;
                            if (words_inc == len_q) begin
                                state_d = S_CSUM;
                            end
                        end
                    endcase
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_d = (bus.rx_data_i == csum_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status lines follow the state being entered so they line up with it.
        if (state_d == S_ERR) begin
            err_d = 1'b1;
        end
        if (state_d == S_DONE) begin
            done_d = 1'b1;
            hold_d = 1'b0;
        end
        ready_d = (state_d != S_DONE);
    end

    // State and output registers; reset abandons any frame and clears every output.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            len_q   <= 16'd0;
            lane_q  <= 2'd0;
            word_q  <= 24'd0;
            csum_q  <= 8'd0;
            words_q <= 16'd0;
            waddr_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            words_q <= words_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign bus.rx_ready_o   = ready_q;
    assign bus.imem_we_o    = we_q;
    assign bus.imem_waddr_o = waddr_q;
    assign bus.imem_wdata_o = wdata_q;
    assign bus.cpu_hold_o   = hold_q;
    assign bus.done_o       = done_q;
    assign bus.err_o        = err_q;
    assign bus.words_o      = words_q;
endmodule
